// File: rtl/puzzle_board.sv
// N x N sliding-puzzle board engine.
// One-hot direction commands move a tile into the empty cell.
module puzzle_board #(
  parameter int N  = 4,
  parameter int PW = $clog2(N*N),
  parameter int CW = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              init,
  input  logic [3:0]        dir,
  input  logic              dir_valid,
  output logic              dir_ready,
  output logic [N*N*PW-1:0] board,
  output logic [PW-1:0]     empty_pos,
  output logic [CW-1:0]     move_count,
  output logic              legal_pulse,
  output logic              illegal_pulse,
  output logic              solved
);

  localparam int NC = N*N;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EVAL = 2'd1;
  localparam logic [1:0] S_SWAP = 2'd2;

  logic [1:0]    state;
  logic [3:0]    dir_q;
  logic [PW-1:0] spos;
  logic [PW-1:0] s_next;
  logic [PW-1:0] e_row;
  logic [PW-1:0] e_col;
  logic [PW-1:0] mv_tile;
  logic          legal;
  logic          sol_now;
  logic [PW-1:0] tiles [NC];

  function automatic logic [PW-1:0] home(input int p);
    return (p == NC-1) ? '0 : PW'(p+1);
  endfunction

  assign dir_ready = (state == S_IDLE);
  assign e_row     = empty_pos / PW'(N);
  assign e_col     = empty_pos % PW'(N);

  for (genvar g = 0; g < NC; g++) begin : g_board
    assign board[g*PW +: PW] = tiles[g];
  end

  // direction names the tile that slides into the hole
  always_comb begin
    legal  = 1'b0;
    s_next = empty_pos;
    case (dir_q)
      4'b1000: begin
        legal  = (e_row < PW'(N-1));
        s_next = empty_pos + PW'(N);
      end
      4'b0100: begin
        legal  = (e_row > '0);
        s_next = empty_pos - PW'(N);
      end
      4'b0010: begin
        legal  = (e_col < PW'(N-1));
        s_next = empty_pos + PW'(1);
      end
      4'b0001: begin
        legal  = (e_col > '0);
        s_next = empty_pos - PW'(1);
      end
      default: begin
        legal  = 1'b0;
        s_next = empty_pos;
      end
    endcase
  end

  always_comb begin
    mv_tile = '0;
    sol_now = 1'b1;
    for (int p = 0; p < NC; p++) begin
      if (PW'(p) == spos)
        mv_tile = tiles[p];
      if (tiles[p] != home(p))
        sol_now = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      dir_q         <= '0;
      spos          <= '0;
      empty_pos     <= PW'(NC-1);
      move_count    <= '0;
      legal_pulse   <= 1'b0;
      illegal_pulse <= 1'b0;
      solved        <= 1'b1;
      for (int p = 0; p < NC; p++)
        tiles[p] <= home(p);
    end else if (init) begin
      state         <= S_IDLE;
      dir_q         <= '0;
      spos          <= '0;
      empty_pos     <= PW'(NC-1);
      move_count    <= '0;
      legal_pulse   <= 1'b0;
      illegal_pulse <= 1'b0;
      solved        <= 1'b1;
      for (int p = 0; p < NC; p++)
        tiles[p] <= home(p);
    end else begin
      legal_pulse   <= 1'b0;
      illegal_pulse <= 1'b0;
      solved        <= sol_now;
      case (state)
        S_IDLE: begin
          if (dir_valid) begin
            dir_q <= dir;
            state <= S_EVAL;
          end
        end
        S_EVAL: begin
          spos <= s_next;
          if (legal) begin
            state <= S_SWAP;
          end else begin
            state         <= S_IDLE;
            illegal_pulse <= 1'b1;
          end
        end
        S_SWAP: begin
          for (int p = 0; p < NC; p++) begin
            if (PW'(p) == empty_pos)
              tiles[p] <= mv_tile;
            else if (PW'(p) == spos)
              tiles[p] <= '0;
          end
          empty_pos <= spos;
          if (move_count != '1)
            move_count <= move_count + CW'(1);
          legal_pulse <= 1'b1;
          state       <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_puzzle_board.sv
// Directed bench for puzzle_board: a 4x4 and a 3x3 (CW=2) instance.
// Each task drives its scenario and checks results inline.
module tb_puzzle_board;

  localparam logic [3:0] UP    = 4'b1000;
  localparam logic [3:0] DOWN  = 4'b0100;
  localparam logic [3:0] LEFT  = 4'b0010;
  localparam logic [3:0] RIGHT = 4'b0001;

  localparam logic [63:0] SOLVED4 = 64'h0FEDCBA987654321;
  localparam logic [35:0] SOLVED3 = 36'h087654321;

  logic        clk;
  logic        reset;
  logic        init;

  logic [3:0]  d4;
  logic        v4;
  logic        rdy4;
  logic [63:0] b4;
  logic [3:0]  e4;
  logic [15:0] mc4;
  logic        lp4;
  logic        ip4;
  logic        sv4;

  logic [3:0]  d3;
  logic        v3;
  logic        rdy3;
  logic [35:0] b3;
  logic [3:0]  e3;
  logic [1:0]  mc3;
  logic        lp3;
  logic        ip3;
  logic        sv3;

  int vecs;
  int errs;

  logic [3:1] lp;
  logic [3:1] ip;
  logic       rdy_eval;

  puzzle_board #(.N(4)) u4 (
    .clk(clk), .reset(reset), .init(init),
    .dir(d4), .dir_valid(v4), .dir_ready(rdy4),
    .board(b4), .empty_pos(e4), .move_count(mc4),
    .legal_pulse(lp4), .illegal_pulse(ip4), .solved(sv4)
  );

  puzzle_board #(.N(3), .CW(2)) u3 (
    .clk(clk), .reset(reset), .init(init),
    .dir(d3), .dir_valid(v3), .dir_ready(rdy3),
    .board(b3), .empty_pos(e3), .move_count(mc3),
    .legal_pulse(lp3), .illegal_pulse(ip3), .solved(sv3)
  );

  always #5 clk = ~clk;

  // stimulus only: called and returns #1 after a rising edge
  task automatic apply_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // handshake one command, then record pulses after E1..E3
  task automatic send(input bit n3, input logic [3:0] d);
    if (n3) begin d3 = d; v3 = 1'b1; end
    else begin d4 = d; v4 = 1'b1; end
    @(posedge clk); #1;
    v3 = 1'b0;
    v4 = 1'b0;
    rdy_eval = n3 ? rdy3 : rdy4;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      lp[k] = n3 ? lp3 : lp4;
      ip[k] = n3 ? ip3 : ip4;
    end
  endtask

  task automatic test_reset();
    apply_reset();
    vecs++;
    if (e4 !== 4'd15) begin
      errs++; $display("FAIL reset_empty: got %0d want 15", e4);
    end
    vecs++;
    if (b4 !== SOLVED4) begin
      errs++; $display("FAIL reset_board: got %h want %h", b4, SOLVED4);
    end
    vecs++;
    if ({sv4, rdy4, lp4, ip4} !== 4'b1100) begin
      errs++;
      $display("FAIL reset_flags: got %b want 1100", {sv4, rdy4, lp4, ip4});
    end
    vecs++;
    if (mc4 !== 16'd0) begin
      errs++; $display("FAIL reset_count: got %0d want 0", mc4);
    end
  endtask

  task automatic test_legal();
    apply_reset();
    send(1'b0, RIGHT);
    vecs++;
    if (rdy_eval !== 1'b0) begin
      errs++; $display("FAIL eval_ready: got %b want 0", rdy_eval);
    end
    vecs++;
    if (lp !== 3'b010 || ip !== 3'b000) begin
      errs++;
      $display("FAIL right_pulses: got lp=%b ip=%b want 010 000", lp, ip);
    end
    vecs++;
    if (e4 !== 4'd14 || b4 !== 64'hF0EDCBA987654321) begin
      errs++;
      $display("FAIL right_board: got e=%0d b=%h want 14 F0EDCBA987654321",
               e4, b4);
    end
    vecs++;
    if (mc4 !== 16'd1 || sv4 !== 1'b0) begin
      errs++;
      $display("FAIL right_count: got %0d/%b want 1/0", mc4, sv4);
    end
    send(1'b0, LEFT);
    vecs++;
    if (e4 !== 4'd15 || b4 !== SOLVED4 || mc4 !== 16'd2 || sv4 !== 1'b1) begin
      errs++;
      $display("FAIL left_back: got e=%0d b=%h c=%0d s=%b want 15 solved 2 1",
               e4, b4, mc4, sv4);
    end
  endtask

  task automatic test_illegal();
    logic [3:0] cmds [4];
    cmds[0] = UP;
    cmds[1] = LEFT;
    cmds[2] = 4'b0011;
    cmds[3] = 4'b0000;
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      send(1'b0, cmds[i]);
      vecs++;
      if (ip !== 3'b001 || lp !== 3'b000) begin
        errs++;
        $display("FAIL illegal_pulse[%0d]: got ip=%b lp=%b want 001 000",
                 i, ip, lp);
      end
      vecs++;
      if (e4 !== 4'd15 || b4 !== SOLVED4 || mc4 !== 16'd0 || sv4 !== 1'b1) begin
        errs++;
        $display("FAIL illegal_hold[%0d]: got e=%0d c=%0d s=%b want 15 0 1",
                 i, e4, mc4, sv4);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] lmask;
    logic [7:0] imask;
    apply_reset();
    send(1'b0, DOWN);
    vecs++;
    if (e4 !== 4'd11 || b4 !== 64'hCFED0BA987654321) begin
      errs++;
      $display("FAIL down_first: got e=%0d b=%h want 11 CFED0BA987654321",
               e4, b4);
    end
    lmask = '0;
    imask = '0;
    d4 = DOWN;
    v4 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      lmask[i] = lp4;
      imask[i] = ip4;
    end
    v4 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vecs++;
    if (lmask !== 8'h24 || imask !== 8'h80) begin
      errs++;
      $display("FAIL stream_pulses: got l=%h i=%h want 24 80", lmask, imask);
    end
    vecs++;
    if (e4 !== 4'd3 || mc4 !== 16'd3 || b4 !== 64'hCFED8BA947650321) begin
      errs++;
      $display("FAIL stream_end: got e=%0d c=%0d b=%h want 3 3 CFED8BA947650321",
               e4, mc4, b4);
    end
  endtask

  task automatic test_abort();
    logic seen;
    apply_reset();
    send(1'b0, RIGHT);
    d4 = RIGHT;
    v4 = 1'b1;
    @(posedge clk); #1;
    v4 = 1'b0;
    init = 1'b1;
    @(posedge clk); #1;
    init = 1'b0;
    vecs++;
    if (rdy4 !== 1'b1 || e4 !== 4'd15 || mc4 !== 16'd0) begin
      errs++;
      $display("FAIL init_now: got r=%b e=%0d c=%0d want 1 15 0",
               rdy4, e4, mc4);
    end
    seen = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      seen = seen | lp4 | ip4;
    end
    vecs++;
    if (seen !== 1'b0) begin
      errs++; $display("FAIL init_pulse: got %b want 0", seen);
    end
    vecs++;
    if (b4 !== SOLVED4 || sv4 !== 1'b1 || mc4 !== 16'd0) begin
      errs++;
      $display("FAIL init_board: got b=%h s=%b c=%0d want solved 1 0",
               b4, sv4, mc4);
    end
    send(1'b0, RIGHT);
    d4 = RIGHT;
    v4 = 1'b1;
    @(posedge clk); #1;
    v4 = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    vecs++;
    if (rdy4 !== 1'b1 || e4 !== 4'd15 || mc4 !== 16'd0 || lp4 !== 1'b0) begin
      errs++;
      $display("FAIL reset_swap: got r=%b e=%0d c=%0d l=%b want 1 15 0 0",
               rdy4, e4, mc4, lp4);
    end
    vecs++;
    if (b4 !== SOLVED4 || sv4 !== 1'b1) begin
      errs++;
      $display("FAIL reset_swap_board: got b=%h s=%b want solved 1", b4, sv4);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    seen = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      seen = seen | lp4 | ip4;
    end
    vecs++;
    if (seen !== 1'b0 || e4 !== 4'd15) begin
      errs++;
      $display("FAIL reset_after: got p=%b e=%0d want 0 15", seen, e4);
    end
  endtask

  task automatic test_n3();
    apply_reset();
    vecs++;
    if (e3 !== 4'd8 || b3 !== SOLVED3 || sv3 !== 1'b1) begin
      errs++;
      $display("FAIL n3_reset: got e=%0d b=%h s=%b want 8 %h 1",
               e3, b3, sv3, SOLVED3);
    end
    send(1'b1, RIGHT);
    send(1'b1, RIGHT);
    vecs++;
    if (e3 !== 4'd6 || mc3 !== 2'd2 || b3 !== 36'h870654321) begin
      errs++;
      $display("FAIL n3_right2: got e=%0d c=%0d b=%h want 6 2 870654321",
               e3, mc3, b3);
    end
    send(1'b1, RIGHT);
    vecs++;
    if (ip !== 3'b001 || e3 !== 4'd6 || mc3 !== 2'd2) begin
      errs++;
      $display("FAIL n3_col0: got ip=%b e=%0d c=%0d want 001 6 2",
               ip, e3, mc3);
    end
    send(1'b1, LEFT);
    vecs++;
    if (e3 !== 4'd7 || mc3 !== 2'd3) begin
      errs++; $display("FAIL n3_move3: got e=%0d c=%0d want 7 3", e3, mc3);
    end
    send(1'b1, LEFT);
    vecs++;
    if (lp !== 3'b010 || e3 !== 4'd8 || mc3 !== 2'd3 || sv3 !== 1'b1) begin
      errs++;
      $display("FAIL n3_sat4: got lp=%b e=%0d c=%0d s=%b want 010 8 3 1",
               lp, e3, mc3, sv3);
    end
    send(1'b1, RIGHT);
    vecs++;
    if (lp !== 3'b010 || e3 !== 4'd7 || mc3 !== 2'd3) begin
      errs++;
      $display("FAIL n3_sat5: got lp=%b e=%0d c=%0d want 010 7 3",
               lp, e3, mc3);
    end
  endtask

  initial begin
    clk   = 1'b0;
    reset = 1'b1;
    init  = 1'b0;
    d4    = '0;
    v4    = 1'b0;
    d3    = '0;
    v3    = 1'b0;
    vecs  = 0;
    errs  = 0;
    lp    = '0;
    ip    = '0;
    rdy_eval = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_legal();
    test_illegal();
    test_back_to_back();
    test_abort();
    test_n3();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/puzzle_board.md
# puzzle_board

Parametrised N×N sliding-puzzle board engine: holds the full tile map and the empty position, and accepts one-hot direction commands over a valid/ready handshake. For each command it checks legality at the board edges, swaps the moving tile with the empty cell, counts legal moves and flags the solved state. It sits between the keyboard/direction front end and the display renderer, and replaces the single-shot combinational legality check with a stateful, size-generic board.

## Interface
- N, default 4: board side; legal 2..8; positions indexed row*N+col, 0 = top-left.
- PW, default $clog2(N*N): width of a position index and of a tile value; tile 0 denotes the empty cell.
- CW, default 16: move-counter width.

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  asynchronous, active-high; forces the solved board (see Operation).
- init  input  1  synchronous re-initialise to the solved board; same effect as reset, one cycle later.
- dir  input  4  command: up=4'b1000, down=4'b0100, left=4'b0010, right=4'b0001.
- dir_valid  input  1  command present.
- dir_ready  output  1  engine can accept a command (high only in IDLE).
- board  output  N*N*PW  tile at position p on board[p*PW +: PW].
- empty_pos  output  PW  current empty position.
- move_count  output  CW  legal moves since reset/init; saturates at all-ones.
- legal_pulse  output  1  one-cycle pulse, a move was applied.
- illegal_pulse  output  1  one-cycle pulse, command rejected.
- solved  output  1  board equals the solved configuration.

## Operation
- Solved configuration: position p holds tile p+1 for p < N*N-1; position N*N-1 holds 0; empty_pos = N*N-1.
- Reset values: board = solved, empty_pos = N*N-1, move_count = 0, legal_pulse = 0, illegal_pulse = 0, solved = 1, state = IDLE, dir_ready = 1.
- Direction means the tile that slides into the empty cell. Let e = empty_pos, r = e/N, c = e%N. The switch position s is:
  - up: legal if r < N-1, s = e+N.
  - down: legal if r > 0, s = e-N.
  - left: legal if c < N-1, s = e+1.
  - right: legal if c > 0, s = e-1.
  - Any other dir value (zero or multi-hot) is illegal.
- FSM:
  - IDLE: dir_ready = 1. When dir_valid is high, capture dir and go to EVAL.
  - EVAL: compute legality and s, register s. If legal, go to SWAP. If illegal, go to IDLE and assert illegal_pulse in the next cycle.
  - SWAP: board[e] ← board[s], board[s] ← 0, empty_pos ← s, move_count += 1 (saturating). Go to IDLE and assert legal_pulse in the next cycle.
- Only the two swapped cells change; all other cells hold.
- An illegal command changes nothing except illegal_pulse.
- init takes priority over everything. A move in EVAL or SWAP at the init edge is discarded: no pulse, no count. The FSM returns to IDLE.
- solved is registered and computed from the board as it stands after each update.

## Timing
- The handshake completes at edge E0 (dir_valid & dir_ready sampled high). The state is EVAL during the next cycle.
- Legal move: board, empty_pos and move_count update at E2. legal_pulse is high during the cycle after E2. solved reflects the new board one cycle after that (updated at E3).
- Illegal move: illegal_pulse is high during the cycle after E1.
- Throughput is one command per 3 cycles. The next command can be accepted in the first IDLE cycle after E1 (illegal) or after E2 (legal).
- dir and dir_valid are ignored outside IDLE. dir is sampled only at the handshake edge.
- Reset asserted mid-operation takes effect immediately, asynchronously. init takes effect at the next clock edge.
- legal_pulse and illegal_pulse are never high together, and never high for two consecutive cycles.

## Test plan
- Reset, N=4: empty_pos=15, board = 1..15,0, solved=1, move_count=0, dir_ready=1, both pulses 0.
- From reset, issue right: legal_pulse 3 cycles after the handshake, empty_pos=14, board[15]=15, board[14]=0, move_count=1, solved=0. Then issue left: empty_pos=15, move_count=2, solved=1.
- From reset, issue up, then left: each produces illegal_pulse 2 cycles after the handshake, with no board, empty_pos or count change. Then issue dir=4'b0011 and dir=4'b0000: both illegal.
- From reset, issue down: empty_pos=11, board[15]=12. Hold dir_valid high continuously with down: moves apply every 3 cycles to empty_pos 7, then 3, then illegal at row 0.
- Issue a legal command and assert init during EVAL: no legal_pulse, move_count=0, board solved. Also pulse reset mid-SWAP: outputs return to reset values immediately.
- N=3 instance: reset gives empty_pos=8. Right twice gives empty_pos=6, move_count=2. A third right is illegal (col 0). Force move_count near saturation with CW=2: the 4th and 5th legal moves leave it at 3.
